// File: rtl/fpga_cfg_pkg.sv
// Shared constants for the CLB configuration path: word layout, packing ratio and loader states.
package fpga_cfg_pkg;

    localparam int CFG_W      = 23;
    localparam int OUT_SEL_HI = 22;
    localparam int OUT_SEL_LO = 19;
    localparam int LUT_OR_FF  = 18;
    localparam int FF_EN_HI   = 17;
    localparam int FF_EN_LO   = 16;
    localparam int LUT_HI     = 15;
    localparam int BPC        = (CFG_W + 7) / 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CHECK,
        DONE,
        ERR
    } cfg_state_e;

endpackage

// File: rtl/clb_cfg_loader.sv
// Packs a byte-wide bitstream into CLB config words, strobes them into CLB 0..NUM_CLB-1
// in order, then validates a trailing XOR checksum byte.
module clb_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_CLB = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid_i,
    output logic               byte_ready_o,
    output logic [NUM_CLB-1:0] wr_en_o,
    output logic [CFG_W-1:0]   bits_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int IDX_W = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;
    localparam int BC_W  = $clog2(BPC + 1);
    localparam int SR_W  = CFG_W - 8;

    cfg_state_e        state;
    logic [IDX_W-1:0]  idx;
    logic [BC_W-1:0]   byte_cnt;
    logic [7:0]        chk;
    logic [SR_W-1:0]   sreg;
    logic [CFG_W-1:0]  word_nxt;
    logic              xfer;

    // Only the low CFG_W bits of the packed bytes are kept; the MSB of the first byte falls off.
    assign word_nxt = {sreg, byte_i};
    assign xfer     = byte_valid_i & byte_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            byte_cnt     <= '0;
            chk          <= '0;
            sreg         <= '0;
            wr_en_o      <= '0;
            bits_o       <= '0;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state        <= LOAD;
                        idx          <= '0;
                        byte_cnt     <= '0;
                        chk          <= '0;
                        done_o       <= 1'b0;
                        err_o        <= 1'b0;
                        busy_o       <= 1'b1;
                        byte_ready_o <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        sreg <= word_nxt[SR_W-1:0];
                        chk  <= chk ^ byte_i;
                        if (byte_cnt == BC_W'(BPC - 1)) begin
                            state        <= WRITE;
                            byte_cnt     <= '0;
                            byte_ready_o <= 1'b0;
                            wr_en_o      <= NUM_CLB'(1) << idx;
                            bits_o       <= word_nxt;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_en_o      <= '0;
                    byte_ready_o <= 1'b1;
                    if (idx == IDX_W'(NUM_CLB - 1)) begin
                        state <= CHECK;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        byte_ready_o <= 1'b0;
                        busy_o       <= 1'b0;
                        if (byte_i == chk) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    wr_en_o      <= '0;
                    byte_ready_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed and randomized bench for clb_cfg_loader with a word/checksum reference model.
module tb_clb_cfg_loader;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [7:0]  byte_v;
    logic        valid;

    logic        ready_a, busy_a, done_a, err_a;
    logic [1:0]  wr_en_a;
    logic [22:0] bits_a;
    logic        ready_b, busy_b, done_b, err_b;
    logic [0:0]  wr_en_b;
    logic [22:0] bits_b;

    int checks;
    int failures;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    clb_cfg_loader #(.NUM_CLB(2)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .byte_i(byte_v), .byte_valid_i(valid),
        .byte_ready_o(ready_a), .wr_en_o(wr_en_a), .bits_o(bits_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    clb_cfg_loader #(.NUM_CLB(1)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .byte_i(byte_v), .byte_valid_i(valid),
        .byte_ready_o(ready_b), .wr_en_o(wr_en_b), .bits_o(bits_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle a strobe is high produces one entry, so a stretched strobe shows up as an extra write.
    always @(negedge clk) begin
        if (wr_en_a != 2'b00) qa.push_back({7'd0, wr_en_a, bits_a});
        if (wr_en_b != 1'b0)  qb.push_back({8'd0, wr_en_b, bits_b});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input bit inst);
        if (inst) start_b = 1'b1; else start_a = 1'b1;
        cycles(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit inst);
        int n;
        n = 0;
        byte_v = b;
        valid  = 1'b1;
        while (!(inst ? ready_b : ready_a) && n < 20) begin
            cycles(1);
            n++;
        end
        check("ready_wait", 32'(n < 20), 32'd1);
        cycles(1);
        valid  = 1'b0;
        byte_v = $urandom_range(0, 255);
    endtask

    task automatic wait_flag(input bit inst);
        int n;
        n = 0;
        while (!(inst ? (done_b | err_b) : (done_a | err_a)) && n < 10) begin
            cycles(1);
            n++;
        end
        check("flag_wait", 32'(n < 10), 32'd1);
    endtask

    // Reference: word k is the big-endian value of bytes 3k..3k+2 modulo 2**23.
    task automatic load_a(input logic [7:0] d[6], input logic [7:0] ck, input int gap,
                          input bit mid_start);
        int unsigned x;
        int unsigned w[2];
        bit good;
        x = 0;
        for (int k = 0; k < 6; k++) x = x ^ int'(d[k]);
        for (int k = 0; k < 2; k++)
            w[k] = ((int'(d[3*k]) * 65536) + (int'(d[3*k+1]) * 256) + int'(d[3*k+2])) % 8388608;
        good = (int'(ck) == x);
        pulse_start(1'b0);
        check("busy_after_start", 32'(busy_a), 32'd1);
        check("done_cleared", 32'(done_a), 32'd0);
        check("err_cleared", 32'(err_a), 32'd0);
        qa.delete();
        for (int i = 0; i < 6; i++) begin
            cycles(gap);
            send(d[i], 1'b0);
            if (mid_start && i == 1) pulse_start(1'b0);
        end
        cycles(gap);
        send(ck, 1'b0);
        wait_flag(1'b0);
        check("write_count", 32'(qa.size()), 32'd2);
        for (int k = 0; k < 2 && k < qa.size(); k++) begin
            check("wr_en_onehot", 32'(qa[k][24:23]), 32'd1 << k);
            check("bits_word", 32'(qa[k][22:0]), w[k]);
        end
        check("done_flag", 32'(done_a), 32'(good));
        check("err_flag", 32'(err_a), 32'(!good));
        check("busy_end", 32'(busy_a), 32'd0);
        check("ready_end", 32'(ready_a), 32'd0);
        check("wr_en_end", 32'(wr_en_a), 32'd0);
    endtask

    logic [7:0] d[6];
    logic [7:0] c1[6];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        valid    = 1'b0;
        byte_v   = 8'h00;
        cycles(3);
        rst = 1'b0;
        cycles(1);

        check("rst_wr_en", 32'(wr_en_a), 32'd0);
        check("rst_bits", 32'(bits_a), 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);

        // Bytes offered while idle must not be taken.
        byte_v = 8'hAA;
        valid  = 1'b1;
        cycles(3);
        check("idle_ready", 32'(ready_a), 32'd0);
        valid = 1'b0;

        c1 = '{8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A};
        load_a(c1, 8'h83, 0, 1'b0);
        check("case1_bits0", (qa.size() > 0) ? qa[0] : 32'hDEAD, 32'h00812345);

        load_a(c1, 8'h00, 0, 1'b0);
        pulse_start(1'b0);
        check("restart_clears_err", 32'(err_a), 32'd0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;

        d = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        load_a(d, 8'hFF, 0, 1'b0);
        check("bit23_dropped", (qa.size() > 0) ? 32'(qa[0][22:0]) : 32'hDEAD, 32'h007FFFFF);

        load_a(c1, 8'h83, 5, 1'b0);

        // Reset part-way through the second word.
        pulse_start(1'b0);
        qa.delete();
        for (int i = 0; i < 4; i++) send(c1[i], 1'b0);
        check("pre_rst_writes", 32'(qa.size()), 32'd1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midrst_wr_en", 32'(wr_en_a), 32'd0);
        check("midrst_bits", 32'(bits_a), 32'd0);
        check("midrst_ready", 32'(ready_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_flags", 32'({done_a, err_a}), 32'd0);
        cycles(4);
        check("post_rst_writes", 32'(qa.size()), 32'd1);
        load_a(c1, 8'h83, 0, 1'b0);

        load_a(c1, 8'h83, 1, 1'b1);

        // Single-CLB instance.
        pulse_start(1'b1);
        qb.delete();
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        send(8'h01, 1'b1);
        wait_flag(1'b1);
        check("b_writes", 32'(qb.size()), 32'd1);
        check("b_word", (qb.size() > 0) ? qb[0] : 32'hDEAD, 32'h00800001);
        check("b_done", 32'(done_b), 32'd1);
        check("b_err", 32'(err_b), 32'd0);

        for (int it = 0; it < 6; it++) begin
            logic [7:0] x;
            x = 8'h00;
            for (int k = 0; k < 6; k++) begin
                d[k] = 8'($urandom_range(0, 255));
                x = x ^ d[k];
            end
            if ($urandom_range(0, 1) == 1) x = x ^ 8'($urandom_range(1, 255));
            load_a(d, x, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
